// File: rtl/phoenix_input_buffer_if.sv
// Link bundle of a Phoenix router input port: credit-based upstream side,
// switch-control request/grant, and the data_av/data_ack crossbar side.
// master = the input buffer, slave = its environment (neighbour, arbiter, crossbar).
interface phoenix_input_buffer_if #(
  parameter int unsigned TAM_FLIT = 16
) ();
  logic                rx;
  logic [TAM_FLIT-1:0] data_in;
  logic                credit_o;
  logic                h;
  logic                ack_h;
  logic                data_av;
  logic [TAM_FLIT-1:0] data;
  logic                data_ack;
  logic                sender;

  modport master (
    input  rx, data_in, ack_h, data_ack,
    output credit_o, h, data_av, data, sender
  );

  modport slave (
    output rx, data_in, ack_h, data_ack,
    input  credit_o, h, data_av, data, sender
  );
endinterface

// File: rtl/phoenix_input_buffer.sv
// Phoenix NoC router input buffer: circular flit FIFO fed over a credit link,
// plus the per-packet FSM that requests the switch and drains header, size and
// payload flits toward the crossbar.
module phoenix_input_buffer #(
  parameter int unsigned TAM_FLIT     = 16,
  parameter int unsigned BUFFER_DEPTH = 16
) (
  input logic                  i_clock,
  input logic                  i_reset_n,
  phoenix_input_buffer_if.master bus
);

  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(BUFFER_DEPTH);

  typedef enum logic [2:0] {StIdle, StReq, StHdr, StSize, StPay} state_e;

  logic [TAM_FLIT-1:0] mem [BUFFER_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]     count_q;
  state_e              state_q, state_d;
  logic [TAM_FLIT-1:0] flit_cnt_q, flit_cnt_d;

  logic                credit;
  logic                empty;
  logic                push;
  logic                pop;
  logic                data_av;
  logic                in_packet;
  logic [TAM_FLIT-1:0] head;

  assign empty     = (count_q == '0);
  assign credit    = (count_q != CountFull);
  assign push      = bus.rx & credit;
  assign in_packet = (state_q == StHdr) || (state_q == StSize) || (state_q == StPay);
  // A starved packet simply stalls here: data_av drops, the FSM waits in place.
  assign data_av   = in_packet & ~empty;
  assign pop       = data_av & bus.data_ack;
  assign head      = mem[rd_ptr_q];

  assign bus.credit_o = credit;
  assign bus.h        = (state_q == StReq);
  assign bus.sender   = in_packet;
  assign bus.data_av  = data_av;
  assign bus.data     = empty ? '0 : head;

  // Flit storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Packet FSM state and remaining-payload counter.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      flit_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  // Next-state: request, then header, size (loads payload count), payload.
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.ack_h) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (pop) begin
          state_d = StSize;
        end
      end
      StSize: begin
        if (pop) begin
          flit_cnt_d = head;
          state_d    = (head == '0) ? StIdle : StPay;
        end
      end
      StPay: begin
        if (pop) begin
          flit_cnt_d = flit_cnt_q - TAM_FLIT'(1);
          if (flit_cnt_q == TAM_FLIT'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_phoenix_input_buffer.sv
// Scoreboard bench for phoenix_input_buffer: accepted flits are queued as
// expected output; a negedge monitor compares every popped flit in order.
module tb_phoenix_input_buffer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] exp_q [$];

  phoenix_input_buffer_if #(.TAM_FLIT(16)) bus ();

  phoenix_input_buffer #(
    .TAM_FLIT    (16),
    .BUFFER_DEPTH(16)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%04h expected=%04h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every pop must match the oldest accepted flit.
  always @(negedge clk) begin
    if (rst_n && bus.data_av && bus.data_ack) begin
      if (exp_q.size() == 0) begin
        chk1("unexpected_pop", 1'b1, 1'b0);
      end else begin
        chk16("pop_data", bus.data, exp_q.pop_front());
        chk1("pop_sender", bus.sender, 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [15:0] d);
    bus.rx      = 1'b1;
    bus.data_in = d;
    exp_q.push_back(d);
    step();
    bus.rx = 1'b0;
  endtask

  task automatic wait_h(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.h && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1(nm, bus.h, 1'b1);
    step();
  endtask

  task automatic grant();
    bus.ack_h = 1'b1;
    step();
    bus.ack_h = 1'b0;
  endtask

  task automatic wait_q(input string nm, input int left);
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() > left && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1(nm, (exp_q.size() == left), 1'b1);
    step();
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.sender) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1(nm, (n < 200), 1'b1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fl [$];
    logic [15:0] v;
    int          idx;
    int          n;
    int          sz;

    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.rx      = 1'b0;
    bus.data_in = '0;
    bus.ack_h   = 1'b0;
    bus.data_ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk1("rst_credit", bus.credit_o, 1'b1);
    chk1("rst_h", bus.h, 1'b0);
    chk1("rst_data_av", bus.data_av, 1'b0);
    chk1("rst_sender", bus.sender, 1'b0);
    chk16("rst_data", bus.data, 16'h0000);
    step();

    // Basic packet, data_ack held high
    bus.data_ack = 1'b1;
    bus.rx = 1'b1; bus.data_in = 16'h0011; exp_q.push_back(16'h0011);
    step();
    bus.data_in = 16'h0002; exp_q.push_back(16'h0002);
    @(negedge clk);
    chk1("t2_h_first_cycle", bus.h, 1'b0);
    step();
    bus.data_in = 16'hAAAA; exp_q.push_back(16'hAAAA);
    @(negedge clk);
    chk1("t2_h_req", bus.h, 1'b1);
    chk1("t2_av_req", bus.data_av, 1'b0);
    step();
    bus.data_in = 16'hBBBB; exp_q.push_back(16'hBBBB);
    bus.ack_h = 1'b1;
    @(negedge clk);
    chk1("t2_h_held", bus.h, 1'b1);
    step();
    bus.rx = 1'b0;
    bus.ack_h = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("t2_av_consecutive", bus.data_av, 1'b1);
      chk1("t2_sender", bus.sender, 1'b1);
      chk1("t2_h_low", bus.h, 1'b0);
      step();
    end
    @(negedge clk);
    chk1("t2_sender_end", bus.sender, 1'b0);
    chk1("t2_av_end", bus.data_av, 1'b0);
    chk1("t2_all_popped", (exp_q.size() == 0), 1'b1);
    step();

    // Full buffer, dropped flit, refill at wrapped write pointer
    bus.data_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        @(negedge clk);
        chk1("t3_credit_before_last", bus.credit_o, 1'b1);
        step();
      end
      v = (i == 0) ? 16'h0033 : (i == 1) ? 16'h000E : 16'(16'h3000 + i);
      push_flit(v);
    end
    @(negedge clk);
    chk1("t3_credit_full", bus.credit_o, 1'b0);
    chk1("t3_h_waiting", bus.h, 1'b1);
    chk1("t3_av_waiting", bus.data_av, 1'b0);
    step();
    bus.rx = 1'b1; bus.data_in = 16'hDEAD;
    @(negedge clk);
    chk1("t3_credit_drop", bus.credit_o, 1'b0);
    step();
    bus.rx = 1'b0;
    grant();
    bus.data_ack = 1'b1;
    bus.rx = 1'b1; bus.data_in = 16'h3FFF;
    @(negedge clk);
    chk1("t3_av_hdr", bus.data_av, 1'b1);
    chk1("t3_credit_pop_cycle", bus.credit_o, 1'b0);
    step();
    bus.data_ack = 1'b0;
    @(negedge clk);
    chk1("t3_credit_after_pop", bus.credit_o, 1'b1);
    exp_q.push_back(16'h3FFF);
    step();
    bus.rx = 1'b0;
    @(negedge clk);
    chk1("t3_credit_refull", bus.credit_o, 1'b0);
    step();
    bus.data_ack = 1'b1;
    wait_q("t3_drain_to_wrapped", 1);
    wait_h("t3_wrapped_req");
    push_flit(16'h0000);
    grant();
    wait_drain("t3_drain");

    // Delayed grant
    push_flit(16'h0044);
    push_flit(16'h0001);
    push_flit(16'h4444);
    wait_h("t4_req");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk1("t4_h_hold", bus.h, 1'b1);
      chk1("t4_av_hold", bus.data_av, 1'b0);
      step();
    end
    grant();
    @(negedge clk);
    chk1("t4_av_after_ack", bus.data_av, 1'b1);
    chk16("t4_hdr", bus.data, 16'h0044);
    step();
    wait_drain("t4_drain");

    // Size 0 packet, then re-request after one idle cycle
    push_flit(16'h0022);
    push_flit(16'h0000);
    push_flit(16'h0055);
    push_flit(16'h0001);
    push_flit(16'h5555);
    wait_h("t5_req");
    grant();
    @(negedge clk);
    chk16("t5_hdr", bus.data, 16'h0022);
    step();
    @(negedge clk);
    chk1("t5_size_av", bus.data_av, 1'b1);
    step();
    @(negedge clk);
    chk1("t5_idle_h", bus.h, 1'b0);
    chk1("t5_idle_sender", bus.sender, 1'b0);
    chk1("t5_idle_av", bus.data_av, 1'b0);
    step();
    @(negedge clk);
    chk1("t5_rereq", bus.h, 1'b1);
    step();
    grant();
    wait_drain("t5_drain");

    // Payload underflow with gaps
    push_flit(16'h0066);
    push_flit(16'h0003);
    wait_h("t6_req");
    grant();
    step();
    step();
    for (int p = 0; p < 3; p++) begin
      repeat (3) begin
        @(negedge clk);
        chk1("t6_gap_av", bus.data_av, 1'b0);
        chk1("t6_gap_sender", bus.sender, 1'b1);
        step();
      end
      push_flit(16'(16'h6600 + p));
      @(negedge clk);
      chk1("t6_pay_av", bus.data_av, 1'b1);
      step();
      @(negedge clk);
      chk1("t6_sender_after_pay", bus.sender, (p < 2));
      step();
    end

    // 20 random packets with random flow control and grants
    for (int p = 0; p < 20; p++) begin
      sz = $urandom_range(0, 4);
      fl.push_back(16'(16'h7000 + p));
      fl.push_back(16'(sz));
      for (int k = 0; k < sz; k++) fl.push_back(16'($urandom_range(0, 65535)));
    end
    idx = 0;
    n   = 0;
    while ((idx < fl.size() || exp_q.size() != 0) && n < 4000) begin
      if (idx < fl.size() && bus.credit_o && $urandom_range(0, 3) != 0) begin
        bus.rx = 1'b1;
        bus.data_in = fl[idx];
        exp_q.push_back(fl[idx]);
        idx++;
      end else begin
        bus.rx = 1'b0;
      end
      bus.ack_h    = bus.h && ($urandom_range(0, 1) == 1);
      bus.data_ack = ($urandom_range(0, 2) != 0);
      step();
      n++;
    end
    bus.rx = 1'b0;
    bus.ack_h = 1'b0;
    bus.data_ack = 1'b1;
    chk1("rand_complete", (n < 4000), 1'b1);
    @(negedge clk);
    chk1("rand_sender_end", bus.sender, 1'b0);
    step();

    // Asynchronous reset mid-packet
    push_flit(16'h0077);
    push_flit(16'h0005);
    push_flit(16'h1111);
    wait_h("t1_req");
    grant();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk1("t1_rst_h", bus.h, 1'b0);
    chk1("t1_rst_av", bus.data_av, 1'b0);
    chk1("t1_rst_sender", bus.sender, 1'b0);
    chk1("t1_rst_credit", bus.credit_o, 1'b1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("t1_post_av", bus.data_av, 1'b0);
    chk16("t1_post_data", bus.data, 16'h0000);
    step();
    @(negedge clk);
    chk1("t1_post_no_req", bus.h, 1'b0);
    chk1("t1_post_credit", bus.credit_o, 1'b1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
